// File: rtl/frame_block_manager.sv
// rtl/frame_block_manager.sv - N-block frame allocator with screenshot hold and drop accounting
// Optional debug port block_state enabled by FRAME_BLOCK_MANAGER_STATUS_EN.
module frame_block_manager #(
    parameter int BLOCK_NUM = 4,
    parameter int BLOCK_W   = (BLOCK_NUM > 2) ? $clog2(BLOCK_NUM) : 1,
    parameter int DROP_W    = 16
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 wr_frame_start,
    input  logic                 wr_frame_end,
    output logic [BLOCK_W-1:0]   wr_block,
    output logic                 wr_block_valid,
    input  logic                 rd_frame_start,
    output logic [BLOCK_W-1:0]   rd_block,
    output logic                 rd_block_valid,
    input  logic                 shot_req,
    input  logic                 shot_release,
    output logic [BLOCK_W-1:0]   shot_block,
    output logic                 shot_valid,
    output logic                 shot_pending,
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
    output logic [3*BLOCK_NUM-1:0] block_state,
`endif
    output logic [DROP_W-1:0]    drop_cnt
);

    typedef enum logic [2:0] {
        ST_FREE    = 3'd0,
        ST_WRITING = 3'd1,
        ST_READY   = 3'd2,
        ST_READING = 3'd3,
        ST_SHOT    = 3'd4
    } blk_state_t;

    blk_state_t st   [BLOCK_NUM];
    blk_state_t st_n [BLOCK_NUM];

    logic [BLOCK_W-1:0] wr_block_n, rd_block_n, shot_block_n;
    logic               wr_block_valid_n, rd_block_valid_n, shot_valid_n, shot_pending_n;
    logic [DROP_W-1:0]  drop_cnt_n;

    logic               w_found, r_found, a_found;
    logic [BLOCK_W-1:0] w_idx, r_idx, a_idx;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // Events are folded in order over st_n so each step sees the previous one's result.
    always_comb begin
        for (int i = 0; i < BLOCK_NUM; i++) st_n[i] = st[i];
        wr_block_n       = wr_block;
        wr_block_valid_n = wr_block_valid;
        rd_block_n       = rd_block;
        rd_block_valid_n = rd_block_valid;
        shot_block_n     = shot_block;
        shot_valid_n     = shot_valid;
        shot_pending_n   = shot_pending;
        drop_cnt_n       = drop_cnt;
        w_found = 1'b0; w_idx = '0;
        r_found = 1'b0; r_idx = '0;
        a_found = 1'b0; a_idx = '0;

        if (wr_frame_end) begin
            for (int i = 0; i < BLOCK_NUM; i++)
                if (st_n[i] == ST_WRITING) begin w_found = 1'b1; w_idx = BLOCK_W'(i); end
            if (w_found) begin
                if (shot_pending_n) begin
                    st_n[w_idx]    = ST_SHOT;
                    shot_block_n   = w_idx;
                    shot_valid_n   = 1'b1;
                    shot_pending_n = 1'b0;
                end else begin
                    for (int i = 0; i < BLOCK_NUM; i++)
                        if (st_n[i] == ST_READY) begin
                            st_n[i]    = ST_FREE;
                            drop_cnt_n = sat_inc(drop_cnt_n);
                        end
                    st_n[w_idx] = ST_READY;
                end
                wr_block_valid_n = 1'b0;
            end
        end

        if (rd_frame_start) begin
            for (int i = 0; i < BLOCK_NUM; i++)
                if (st_n[i] == ST_READY) begin r_found = 1'b1; r_idx = BLOCK_W'(i); end
            if (r_found) begin
                for (int i = 0; i < BLOCK_NUM; i++)
                    if (st_n[i] == ST_READING) st_n[i] = ST_FREE;
                st_n[r_idx]      = ST_READING;
                rd_block_n       = r_idx;
                rd_block_valid_n = 1'b1;
            end
        end

        if (wr_frame_start) begin
            for (int i = 0; i < BLOCK_NUM; i++)
                if (st_n[i] == ST_WRITING) begin
                    st_n[i]    = ST_FREE;
                    drop_cnt_n = sat_inc(drop_cnt_n);
                end
            // Descending scan so the lowest FREE index wins.
            for (int i = BLOCK_NUM - 1; i >= 0; i--)
                if (st_n[i] == ST_FREE) begin a_found = 1'b1; a_idx = BLOCK_W'(i); end
            if (!a_found) begin
                for (int i = 0; i < BLOCK_NUM; i++)
                    if (st_n[i] == ST_READY) begin a_found = 1'b1; a_idx = BLOCK_W'(i); end
                if (a_found) drop_cnt_n = sat_inc(drop_cnt_n);
            end
            if (a_found) begin
                st_n[a_idx]      = ST_WRITING;
                wr_block_n       = a_idx;
                wr_block_valid_n = 1'b1;
            end else begin
                wr_block_valid_n = 1'b0;
            end
        end

        if (shot_release) begin
            for (int i = 0; i < BLOCK_NUM; i++)
                if (st_n[i] == ST_SHOT) begin
                    st_n[i]      = ST_FREE;
                    shot_valid_n = 1'b0;
                end
        end

        if (shot_req && !shot_valid_n && !shot_pending_n)
            shot_pending_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            for (int i = 0; i < BLOCK_NUM; i++) st[i] <= ST_FREE;
            wr_block       <= '0;
            wr_block_valid <= 1'b0;
            rd_block       <= '0;
            rd_block_valid <= 1'b0;
            shot_block     <= '0;
            shot_valid     <= 1'b0;
            shot_pending   <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            for (int i = 0; i < BLOCK_NUM; i++) st[i] <= st_n[i];
            wr_block       <= wr_block_n;
            wr_block_valid <= wr_block_valid_n;
            rd_block       <= rd_block_n;
            rd_block_valid <= rd_block_valid_n;
            shot_block     <= shot_block_n;
            shot_valid     <= shot_valid_n;
            shot_pending   <= shot_pending_n;
            drop_cnt       <= drop_cnt_n;
        end
    end

`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
    for (genvar g = 0; g < BLOCK_NUM; g++) begin : g_status
        assign block_state[3*g +: 3] = st[g];
    end
`endif

endmodule

// File: tb/tb_frame_block_manager.sv
// tb/tb_frame_block_manager.sv - scoreboard bench for frame_block_manager (4-block and 3-block instances)
module tb_frame_block_manager;

    logic clk = 1'b0;
    logic rest = 1'b1;
    logic wr_frame_start = 1'b0, wr_frame_end = 1'b0, rd_frame_start = 1'b0;
    logic shot_req = 1'b0, shot_release = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  wb4, rb4, sb4;
    logic        wv4, rv4, sv4, sp4;
    logic [15:0] drop4;
    logic [1:0]  wb3, rb3, sb3;
    logic        wv3, rv3, sv3, sp3;
    logic [2:0]  drop3;
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
    logic [11:0] bs4;
    logic [8:0]  bs3;
`endif

    frame_block_manager #(.BLOCK_NUM(4), .DROP_W(16)) dut4 (
        .clk(clk), .rest(rest),
        .wr_frame_start(wr_frame_start), .wr_frame_end(wr_frame_end),
        .wr_block(wb4), .wr_block_valid(wv4),
        .rd_frame_start(rd_frame_start), .rd_block(rb4), .rd_block_valid(rv4),
        .shot_req(shot_req), .shot_release(shot_release),
        .shot_block(sb4), .shot_valid(sv4), .shot_pending(sp4),
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
        .block_state(bs4),
`endif
        .drop_cnt(drop4)
    );

    frame_block_manager #(.BLOCK_NUM(3), .DROP_W(3)) dut3 (
        .clk(clk), .rest(rest),
        .wr_frame_start(wr_frame_start), .wr_frame_end(wr_frame_end),
        .wr_block(wb3), .wr_block_valid(wv3),
        .rd_frame_start(rd_frame_start), .rd_block(rb3), .rd_block_valid(rv3),
        .shot_req(shot_req), .shot_release(shot_release),
        .shot_block(sb3), .shot_valid(sv3), .shot_pending(sp3),
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
        .block_state(bs3),
`endif
        .drop_cnt(drop3)
    );

    typedef struct packed {
        logic [3:0]  wb;
        logic        wv;
        logic [3:0]  rb;
        logic        rv;
        logic [3:0]  sb;
        logic        sv;
        logic        sp;
        logic [15:0] drop;
        logic [47:0] bs;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: one role slot per kind (-1 = nobody holds it); FREE is "in no slot".
    int nb   [2] = '{4, 3};
    int dmax [2] = '{65535, 7};
    int m_w[2], m_rdy[2], m_rd[2], m_sh[2];
    int m_wb[2], m_wv[2], m_rb[2], m_rv[2], m_sb[2], m_sv[2], m_sp[2], m_drop[2];

    task automatic bump(input int k);
        if (m_drop[k] < dmax[k]) m_drop[k]++;
    endtask

    task automatic model_step(input int k, input bit we, input bit rs, input bit ws,
                              input bit sr, input bit sq, input bit rst_in);
        int p;
        if (rst_in) begin
            m_w[k] = -1; m_rdy[k] = -1; m_rd[k] = -1; m_sh[k] = -1;
            m_wb[k] = 0; m_wv[k] = 0; m_rb[k] = 0; m_rv[k] = 0;
            m_sb[k] = 0; m_sv[k] = 0; m_sp[k] = 0; m_drop[k] = 0;
            return;
        end
        if (we && m_w[k] >= 0) begin
            if (m_sp[k] != 0) begin
                m_sh[k] = m_w[k]; m_sb[k] = m_w[k]; m_sv[k] = 1; m_sp[k] = 0;
            end else begin
                if (m_rdy[k] >= 0) bump(k);
                m_rdy[k] = m_w[k];
            end
            m_w[k] = -1;
            m_wv[k] = 0;
        end
        if (rs && m_rdy[k] >= 0) begin
            m_rd[k] = m_rdy[k]; m_rdy[k] = -1;
            m_rb[k] = m_rd[k]; m_rv[k] = 1;
        end
        if (ws) begin
            if (m_w[k] >= 0) begin m_w[k] = -1; bump(k); end
            p = -1;
            for (int i = 0; i < nb[k]; i++)
                if (p < 0 && i != m_rdy[k] && i != m_rd[k] && i != m_sh[k]) p = i;
            if (p < 0 && m_rdy[k] >= 0) begin p = m_rdy[k]; m_rdy[k] = -1; bump(k); end
            if (p >= 0) begin m_w[k] = p; m_wb[k] = p; m_wv[k] = 1; end
            else m_wv[k] = 0;
        end
        if (sr && m_sh[k] >= 0) begin m_sh[k] = -1; m_sv[k] = 0; end
        if (sq && m_sv[k] == 0 && m_sp[k] == 0) m_sp[k] = 1;
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        int code;
        o = '0;
        o.wb = 4'(m_wb[k]); o.wv = m_wv[k][0];
        o.rb = 4'(m_rb[k]); o.rv = m_rv[k][0];
        o.sb = 4'(m_sb[k]); o.sv = m_sv[k][0]; o.sp = m_sp[k][0];
        o.drop = 16'(m_drop[k]);
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
        for (int i = 0; i < nb[k]; i++) begin
            code = (i == m_w[k]) ? 1 : (i == m_rdy[k]) ? 2 : (i == m_rd[k]) ? 3 : (i == m_sh[k]) ? 4 : 0;
            o.bs[3*i +: 3] = 3'(code);
        end
`else
        code = 0;
        o.bs = 48'(code);
`endif
        return o;
    endfunction

    function automatic obs_t dut_obs(input int k);
        obs_t o;
        o = '0;
        if (k == 0) begin
            o.wb = 4'(wb4); o.wv = wv4; o.rb = 4'(rb4); o.rv = rv4;
            o.sb = 4'(sb4); o.sv = sv4; o.sp = sp4; o.drop = drop4;
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
            o.bs = 48'(bs4);
`endif
        end else begin
            o.wb = 4'(wb3); o.wv = wv3; o.rb = 4'(rb3); o.rv = rv3;
            o.sb = 4'(sb3); o.sv = sv3; o.sp = sp3; o.drop = 16'(drop3);
`ifdef FRAME_BLOCK_MANAGER_STATUS_EN
            o.bs = 48'(bs3);
`endif
        end
        return o;
    endfunction

    int cyc = 0;

    task automatic drive(input bit we, input bit rs, input bit ws,
                         input bit sr, input bit sq, input bit rst_in);
        @(negedge clk);
        wr_frame_end = we; rd_frame_start = rs; wr_frame_start = ws;
        shot_release = sr; shot_req = sq; rest = rst_in;
        for (int k = 0; k < 2; k++) model_step(k, we, rs, ws, sr, sq, rst_in);
        exp_q0.push_back(model_obs(0));
        exp_q1.push_back(model_obs(1));
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        obs_t e, a;
        #1;
        cyc++;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front(); a = dut_obs(0);
            total_cnt++;
            if (a !== e) $display("FAIL blk4 cycle %0d: got %h required %h", cyc, a, e);
            else pass_cnt++;
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front(); a = dut_obs(1);
            total_cnt++;
            if (a !== e) $display("FAIL blk3 cycle %0d: got %h required %h", cyc, a, e);
            else pass_cnt++;
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        idle();
        // First frame end-to-end.
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        // Two frames with no read, then a read.
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        // Reads with nothing READY.
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        // Screenshot hold across many frames, then release.
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        repeat (10) begin
            drive(0, 0, 1, 0, 1, 0); drive(1, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 1, 0, 0);
        repeat (3) begin drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); end
        // End and read in the same cycle.
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        idle();
        // SHOT + READING + READY held, then allocate: 3-block instance must steal READY.
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        // Reset mid-write.
        drive(0, 0, 0, 0, 0, 1);
        idle();
        // Randomised traffic, including same-cycle combinations and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 999) < 4);
        end
        idle();
        for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(negedge clk);
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/frame_block_manager.md
Name: frame_block_manager

Overview:
- Parametrised SDRAM frame-block allocator for the camera-to-HDMI path, clocked on sys_clk.
- Tracks BLOCK_NUM frame blocks, each in one of FREE / WRITING / READY / READING / SHOT.
- Hands the writer (frame_write) a free block and the reader (frame_read) the newest completed frame.
- Generalises the fixed disp/occupy block exchange to N blocks, adds screenshot capture and dropped-frame accounting.

Parameters:
- BLOCK_NUM, 4, number of frame blocks; legal range 3..16; 4 or more required when screenshot is used.
- BLOCK_W, $clog2(BLOCK_NUM) (minimum 1), width of every block index.
- DROP_W, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock.
- rest  in  1  asynchronous, active-high reset.
- wr_frame_start  in  1  one-cycle pulse: writer begins a frame.
- wr_frame_end  in  1  one-cycle pulse: writer completed the frame.
- wr_block  out  BLOCK_W  block the writer must fill.
- wr_block_valid  out  1  wr_block is owned by the writer; 0 means the writer discards the frame.
- rd_frame_start  in  1  one-cycle pulse at reader vsync.
- rd_block  out  BLOCK_W  block the reader must display.
- rd_block_valid  out  1  reader owns rd_block.
- shot_req  in  1  pulse: capture the next completed frame.
- shot_release  in  1  pulse: free the held screenshot block.
- shot_block  out  BLOCK_W  held screenshot block.
- shot_valid  out  1  a screenshot block is held.
- shot_pending  out  1  shot_req accepted, capture not yet done.
- drop_cnt  out  DROP_W  saturating count of frames written but never displayed, plus aborted frames.

Behaviour:
- Reset: all blocks FREE. All index outputs 0; all valid/pending outputs 0; drop_cnt 0. Reset mid-frame abandons all ownership immediately.
- State encoding per block (3 bits): FREE=0, WRITING=1, READY=2, READING=3, SHOT=4.
- Invariant: at most one block each in WRITING, READY, READING and SHOT.
- All outputs registered; each update is visible on the cycle after the input pulse (latency 1).
- Same-cycle events are applied sequentially in this order, each seeing the result of the previous step:
  1. wr_frame_end
  2. rd_frame_start
  3. wr_frame_start
  4. shot_release
  5. shot_req
- wr_frame_end:
  - No WRITING block: ignored.
  - shot_pending=1: WRITING goes to SHOT; shot_block is set; shot_valid=1; shot_pending=0.
  - Otherwise WRITING goes to READY. Any previous READY block goes to FREE, and drop_cnt increments.
  - wr_block_valid goes to 0.
- rd_frame_start:
  - READY block exists: the previous READING block (if any) goes to FREE; READY goes to READING; rd_block is updated; rd_block_valid=1.
  - No READY block: nothing changes; the reader repeats its frame and keeps its validity.
- wr_frame_start:
  - If a block is still WRITING, it is aborted to FREE and drop_cnt increments.
  - Allocation picks the lowest-index FREE block.
  - If no block is FREE, the READY block is taken instead and drop_cnt increments.
  - If neither exists, wr_block_valid=0 and wr_block is unchanged.
  - On successful allocation: the block goes to WRITING, wr_block is set, wr_block_valid=1.
- shot_release: the SHOT block goes to FREE; shot_valid=0; shot_block holds its last value. Ignored if no block is SHOT.
- shot_req: sets shot_pending=1 only when shot_valid=0 and shot_pending=0; otherwise ignored.
- drop_cnt saturates at all-ones and never wraps.
- Block indices ≥ BLOCK_NUM are never produced.

Optional Feature:
- Macro: FRAME_BLOCK_MANAGER_STATUS_EN.
- Defined: adds output block_state (3*BLOCK_NUM bits; block i at [3i+2:3i]) carrying the registered per-block state, for SignalTap or a debug register.
- Undefined: the port is absent; all other behaviour is identical.

Test Plan:
- Reset, wr_frame_start -> next cycle wr_block=0, wr_block_valid=1. Then wr_frame_end, then rd_frame_start -> rd_block=0, rd_block_valid=1, drop_cnt=0.
- Two full write frames, no read -> second frame uses block 1; its end frees block 0; drop_cnt=1. Then rd_frame_start -> rd_block=1.
- rd_frame_start with no READY block -> rd_block and rd_block_valid unchanged across 3 consecutive pulses.
- shot_req, then full write frame into block k -> shot_valid=1, shot_block=k, shot_pending=0. Block k is never reallocated over 10 frames; after shot_release, block k is allocatable again.
- wr_frame_end and rd_frame_start in the same cycle -> reader receives the just-completed block; its former block is FREE on the next cycle.
- BLOCK_NUM=3: hold one SHOT, one READING, one READY; wr_frame_start -> wr_block is the READY block, drop_cnt increments. Assert rest mid-write -> all outputs 0 and all blocks FREE (with FRAME_BLOCK_MANAGER_STATUS_EN defined, block_state=0).
